// File: rtl/stream_count_checker_pkg.sv
// Shared types and helpers for the stream count checker.
// Holds the FSM encoding, the error counter width and a saturating increment.
package stream_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    localparam int ERR_CNT_W = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/stream_count_checker_ready_pattern_gen.sv
// 16-bit rotate-right back-pressure pattern; bit 0 is this cycle's ready enable.
// Reused wherever a repeating ready mask is needed.
module ready_pattern_gen #(
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] load_val,
    output logic        pat0
);

    logic [15:0] pat_q, pat_d;

    always_comb begin
        pat_d = pat_q;
        if (load) begin
            pat_d = load_val;
        end else if (en) begin
            pat_d = {pat_q[0], pat_q[15:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            pat_q <= INIT;
        end else begin
            pat_q <= pat_d;
        end
    end

    assign pat0 = pat_q[0];

endmodule

// File: rtl/stream_count_checker.sv
// Consumes one frame from the file streamer, checks every word against an arithmetic
// count sequence and checks the eof position; reports counts and the first mismatch.
module stream_count_checker
    import stream_chk_pkg::*;
#(
    parameter int          FRAME_SIZE    = 65536,
    parameter logic [31:0] START_VAL     = 32'h0,
    parameter logic [31:0] STEP          = 32'h1,
    parameter logic [15:0] READY_PATTERN = 16'hFFFF,
    parameter int          CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 start,
    input  logic [31:0]          din,
    input  logic                 valid,
    input  logic                 eof,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 len_err,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [31:0]          first_err_data,
    output logic [31:0]          first_err_exp
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_SIZE - 1);

    chk_state_t           state_q, state_d;
    logic [31:0]          exp_q, exp_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 len_q, len_d;
    logic [CNT_W-1:0]     fidx_q, fidx_d;
    logic [31:0]          fdata_q, fdata_d;
    logic [31:0]          fexp_q, fexp_d;

    logic pat0;
    logic in_run;
    logic arm;
    logic xfer;

    assign in_run = (state_q == RUN);
    assign arm    = start & ~in_run;
    assign ready  = in_run & pat0;
    assign xfer   = valid & ready;

    ready_pattern_gen #(
        .INIT (READY_PATTERN)
    ) u_pat (
        .clk      (clk),
        .rstb     (rstb),
        .load     (arm),
        .en       (in_run),
        .load_val (READY_PATTERN),
        .pat0     (pat0)
    );

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        len_d   = len_q;
        fidx_d  = fidx_q;
        fdata_d = fdata_q;
        fexp_d  = fexp_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    exp_d   = START_VAL;
                    wcnt_d  = '0;
                    err_d   = '0;
                    len_d   = 1'b0;
                    fidx_d  = '0;
                    fdata_d = '0;
                    fexp_d  = '0;
                end
            end
            RUN: begin
                if (xfer) begin
                    wcnt_d = wcnt_q + 1'b1;
                    // expected free-runs so one bad word costs exactly one error
                    exp_d  = exp_q + STEP;
                    if (din != exp_q) begin
                        err_d = sat_inc(err_q);
                        if (err_q == '0) begin
                            fidx_d  = wcnt_q;
                            fdata_d = din;
                            fexp_d  = exp_q;
                        end
                    end
                    if (eof) begin
                        state_d = DONE;
                        len_d   = (wcnt_q != LAST_IDX);
                    end else if (wcnt_q == LAST_IDX) begin
                        state_d = DONE;
                        len_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            exp_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= '0;
            len_q   <= 1'b0;
            fidx_q  <= '0;
            fdata_q <= '0;
            fexp_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            len_q   <= len_d;
            fidx_q  <= fidx_d;
            fdata_q <= fdata_d;
            fexp_q  <= fexp_d;
        end
    end

    assign busy           = in_run;
    assign done           = (state_q == DONE);
    assign pass           = done & (err_q == '0) & ~len_q;
    assign len_err        = len_q;
    assign word_cnt       = wcnt_q;
    assign err_cnt        = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdata_q;
    assign first_err_exp  = fexp_q;

endmodule

// File: tb/tb_stream_count_checker.sv
// Directed bench: three checker instances (plain, 5555 back-pressure, wrapping start)
// share one stream source; a selector routes the source to the instance under test.
module tb_stream_count_checker;

    logic        clk = 1'b0;
    logic        rstb;
    logic [31:0] din;
    logic        valid;
    logic        eof;

    logic        st  [3];
    logic        rdy [3];
    logic        bsy [3];
    logic        dn  [3];
    logic        ps  [3];
    logic        le  [3];
    logic [31:0] wc  [3];
    logic [15:0] ec  [3];
    logic [31:0] fi  [3];
    logic [31:0] fd  [3];
    logic [31:0] fe  [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stream_count_checker #(.FRAME_SIZE(16), .START_VAL(32'h0), .STEP(32'h1),
                           .READY_PATTERN(16'hFFFF), .CNT_W(32)) u_dut_a (
        .clk(clk), .rstb(rstb), .start(st[0]), .din(din), .valid(valid), .eof(eof),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .len_err(le[0]),
        .word_cnt(wc[0]), .err_cnt(ec[0]), .first_err_idx(fi[0]),
        .first_err_data(fd[0]), .first_err_exp(fe[0]));

    stream_count_checker #(.FRAME_SIZE(16), .START_VAL(32'h0), .STEP(32'h1),
                           .READY_PATTERN(16'h5555), .CNT_W(32)) u_dut_p (
        .clk(clk), .rstb(rstb), .start(st[1]), .din(din), .valid(valid), .eof(eof),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .len_err(le[1]),
        .word_cnt(wc[1]), .err_cnt(ec[1]), .first_err_idx(fi[1]),
        .first_err_data(fd[1]), .first_err_exp(fe[1]));

    stream_count_checker #(.FRAME_SIZE(16), .START_VAL(32'hFFFF_FFFE), .STEP(32'h1),
                           .READY_PATTERN(16'hFFFF), .CNT_W(32)) u_dut_w (
        .clk(clk), .rstb(rstb), .start(st[2]), .din(din), .valid(valid), .eof(eof),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .len_err(le[2]),
        .word_cnt(wc[2]), .err_cnt(ec[2]), .first_err_idx(fi[2]),
        .first_err_data(fd[2]), .first_err_exp(fe[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ends at a negedge with start low
    task automatic pulse_start(input int sel);
        @(negedge clk);
        valid   = 1'b0;
        eof     = 1'b0;
        st[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[sel] = 1'b0;
    endtask

    // Feeds words base+i from index i0; stops on done, after n_limit transfers, or on timeout.
    // Called and returns at a negedge.
    task automatic run_frame(input int sel, input logic [31:0] base, input int corrupt,
                             input int eof_idx, input int i0, input int n_limit,
                             output int xfers, output int cyc);
        int  i;
        logic x;
        i   = i0;
        cyc = 0;
        while (cyc < 200) begin
            if (dn[sel] || (i - i0) == n_limit) break;
            din   = (i == corrupt) ? 32'hDEAD_BEEF : base + 32'(i);
            valid = 1'b1;
            eof   = (i == eof_idx);
            x     = rdy[sel];
            @(posedge clk);
            cyc++;
            if (x) i++;
            @(negedge clk);
        end
        valid = 1'b0;
        eof   = 1'b0;
        xfers = i - i0;
        if (cyc >= 200) chk("timeout", 32'(cyc), 32'd0);
    endtask

    task automatic chk_idle(input string tag, input int sel);
        chk({tag, "_rdy"},  32'(rdy[sel]), 32'd0);
        chk({tag, "_busy"}, 32'(bsy[sel]), 32'd0);
        chk({tag, "_done"}, 32'(dn[sel]),  32'd0);
        chk({tag, "_pass"}, 32'(ps[sel]),  32'd0);
        chk({tag, "_len"},  32'(le[sel]),  32'd0);
        chk({tag, "_wcnt"}, wc[sel],       32'd0);
        chk({tag, "_err"},  32'(ec[sel]),  32'd0);
        chk({tag, "_fidx"}, fi[sel],       32'd0);
        chk({tag, "_fdat"}, fd[sel],       32'd0);
        chk({tag, "_fexp"}, fe[sel],       32'd0);
    endtask

    initial begin
        int xf, cy;
        rstb  = 1'b0;
        din   = '0;
        valid = 1'b0;
        eof   = 1'b0;
        for (int k = 0; k < 3; k++) st[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("rst_a", 0);
        chk_idle("rst_p", 1);
        rstb = 1'b1;

        // 1: clean frame
        pulse_start(0);
        chk("t1_busy", 32'(bsy[0]), 32'd1);
        chk("t1_rdy", 32'(rdy[0]), 32'd1);
        run_frame(0, 32'h0, -1, 15, 0, 1000, xf, cy);
        chk("t1_cyc", 32'(cy), 32'd16);
        chk("t1_done", 32'(dn[0]), 32'd1);
        chk("t1_busy_end", 32'(bsy[0]), 32'd0);
        chk("t1_wcnt", wc[0], 32'd16);
        chk("t1_err", 32'(ec[0]), 32'd0);
        chk("t1_len", 32'(le[0]), 32'd0);
        chk("t1_pass", 32'(ps[0]), 32'd1);

        // 2: single corrupted word
        pulse_start(0);
        chk("t2_clr_done", 32'(dn[0]), 32'd0);
        run_frame(0, 32'h0, 5, 15, 0, 1000, xf, cy);
        chk("t2_err", 32'(ec[0]), 32'd1);
        chk("t2_fidx", fi[0], 32'd5);
        chk("t2_fdat", fd[0], 32'hDEAD_BEEF);
        chk("t2_fexp", fe[0], 32'd5);
        chk("t2_len", 32'(le[0]), 32'd0);
        chk("t2_pass", 32'(ps[0]), 32'd0);

        // 3a: early eof
        pulse_start(0);
        run_frame(0, 32'h0, -1, 9, 0, 1000, xf, cy);
        chk("t3a_cyc", 32'(cy), 32'd10);
        chk("t3a_wcnt", wc[0], 32'd10);
        chk("t3a_len", 32'(le[0]), 32'd1);
        chk("t3a_err", 32'(ec[0]), 32'd0);
        chk("t3a_pass", 32'(ps[0]), 32'd0);
        // 3b: missing eof, then extra words must stay unconsumed
        pulse_start(0);
        run_frame(0, 32'h0, -1, -1, 0, 1000, xf, cy);
        chk("t3b_cyc", 32'(cy), 32'd16);
        chk("t3b_len", 32'(le[0]), 32'd1);
        din   = 32'd16;
        valid = 1'b1;
        eof   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t3b_rdy", 32'(rdy[0]), 32'd0);
        chk("t3b_wcnt", wc[0], 32'd16);
        chk("t3b_done", 32'(dn[0]), 32'd1);
        valid = 1'b0;
        eof   = 1'b0;

        // 4: 5555 back-pressure
        pulse_start(1);
        chk("t4_rdy0", 32'(rdy[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t4_rdy1", 32'(rdy[1]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t4_rdy2", 32'(rdy[1]), 32'd1);
        chk("t4_novalid_wcnt", wc[1], 32'd0);
        pulse_start(1);
        pulse_start(1);
        // mid-RUN start pulses above are ignored; pattern is at an even phase again
        chk("t4_rdy_again", 32'(rdy[1]), 32'd1);
        run_frame(1, 32'h0, -1, 15, 0, 1000, xf, cy);
        chk("t4_cyc", 32'(cy), 32'd31);
        chk("t4_wcnt", wc[1], 32'd16);
        chk("t4_pass", 32'(ps[1]), 32'd1);
        // restart reloads the pattern to its first phase
        pulse_start(1);
        chk("t4_reload_rdy", 32'(rdy[1]), 32'd1);
        run_frame(1, 32'h0, -1, 15, 0, 1000, xf, cy);
        chk("t4b_cyc", 32'(cy), 32'd31);
        chk("t4b_pass", 32'(ps[1]), 32'd1);

        // 5: wrap across 2^32
        pulse_start(2);
        run_frame(2, 32'hFFFF_FFFE, -1, 15, 0, 1000, xf, cy);
        chk("t5_err", 32'(ec[2]), 32'd0);
        chk("t5_wcnt", wc[2], 32'd16);
        chk("t5_pass", 32'(ps[2]), 32'd1);

        // 6: reset mid-frame, then clean rerun, then ignored start mid-RUN
        pulse_start(0);
        run_frame(0, 32'h0, 2, 15, 0, 7, xf, cy);
        chk("t6_wcnt7", wc[0], 32'd7);
        din   = 32'd7;
        valid = 1'b1;
        rstb  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        chk_idle("t6_rst", 0);
        rstb = 1'b1;
        pulse_start(0);
        run_frame(0, 32'h0, -1, 15, 0, 1000, xf, cy);
        chk("t6_rerun_pass", 32'(ps[0]), 32'd1);
        pulse_start(0);
        run_frame(0, 32'h0, -1, 15, 0, 4, xf, cy);
        pulse_start(0);
        chk("t6_ign_wcnt", wc[0], 32'd4);
        chk("t6_ign_busy", 32'(bsy[0]), 32'd1);
        run_frame(0, 32'h0, -1, 15, 4, 1000, xf, cy);
        chk("t6_ign_cyc", 32'(cy), 32'd12);
        chk("t6_ign_wcnt_end", wc[0], 32'd16);
        chk("t6_ign_pass", 32'(ps[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
